// File: rtl/perf_monitor.sv
// perf_monitor: saturating stall/flush/retire/cycle counters with snapshot port and idle-loop halt detection (halt logic built only with PERF_MON_HALT_DETECT_EN)
module perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int HALT_WINDOW = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic [31:0]      pc_i,
  input  logic             snap_req_i,
  output logic             snap_valid_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] snap_cycle_o,
  output logic [CNT_W-1:0] snap_stall_o,
  output logic [CNT_W-1:0] snap_flush_o,
  output logic [CNT_W-1:0] snap_retire_o,
  output logic             halt_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d, ret_q, ret_d;
  logic [CNT_W-1:0] s_cyc_q, s_stl_q, s_fls_q, s_ret_q;
  logic             valid_q, req_q;
  logic             cnt_en, idle_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != '1) ? v + 1'b1 : v;
  endfunction

  // counting happens on every edge the monitor is (or is entering) RUN with the CPU enabled
  assign cnt_en = start_i && state_q != HALTED;

`ifdef PERF_MON_HALT_DETECT_EN
  localparam logic [7:0] HW = 8'(HALT_WINDOW);
  logic [7:0]  idle_q, idle_d;
  logic [31:0] pc_q;
  logic        halt_q;
  // idle run length: PC unchanged and nothing retired; restarts after a halt is declared
  always_comb begin
    idle_d = (clear_i || state_q == HALTED) ? '0 :
             !cnt_en                        ? idle_q :
             (pc_i != pc_q || retire_i)     ? '0 :
             (idle_q == HW)                 ? idle_q : idle_q + 8'd1;
  end
  assign idle_hit = idle_d == HW;
  // idle counter, last-cycle PC and registered halt flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_q <= '0;
      pc_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      pc_q   <= pc_i;
      halt_q <= state_d == HALTED;
    end
  end
  assign halt_o = halt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{pc_i, 8'(HALT_WINDOW)};
  assign idle_hit   = 1'b0;
  assign halt_o     = 1'b0;
`endif

  // next state; clear overrides every transition and lands in RUN when the CPU is enabled
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_i ? RUN : IDLE;
      RUN:     state_d = !start_i ? IDLE : idle_hit ? HALTED : RUN;
      HALTED:  state_d = start_i ? HALTED : IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = start_i ? RUN : IDLE;
  end

  // next counter values; a flush wins over a simultaneous stall
  always_comb begin
    cyc_d = clear_i ? '0 : sat_inc(cyc_q, cnt_en);
    stl_d = clear_i ? '0 : sat_inc(stl_q, cnt_en && stall_i && !flush_i);
    fls_d = clear_i ? '0 : sat_inc(fls_q, cnt_en && flush_i);
    ret_d = clear_i ? '0 : sat_inc(ret_q, cnt_en && retire_i);
  end

  // state register and live counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      stl_q   <= '0;
      fls_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stl_q   <= stl_d;
      fls_q   <= fls_d;
      ret_q   <= ret_d;
    end
  end

  // snapshot captures post-update counters on a request rising edge; valid drops once the request is seen low
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      s_cyc_q <= '0;
      s_stl_q <= '0;
      s_fls_q <= '0;
      s_ret_q <= '0;
    end else begin
      req_q <= snap_req_i;
      if (clear_i) begin
        valid_q <= 1'b0;
        s_cyc_q <= '0;
        s_stl_q <= '0;
        s_fls_q <= '0;
        s_ret_q <= '0;
      end else if (snap_req_i && !req_q) begin
        valid_q <= 1'b1;
        s_cyc_q <= cyc_d;
        s_stl_q <= stl_d;
        s_fls_q <= fls_d;
        s_ret_q <= ret_d;
      end else if (!snap_req_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign cycle_cnt_o   = cyc_q;
  assign stall_cnt_o   = stl_q;
  assign flush_cnt_o   = fls_q;
  assign retire_cnt_o  = ret_q;
  assign snap_cycle_o  = s_cyc_q;
  assign snap_stall_o  = s_stl_q;
  assign snap_flush_o  = s_fls_q;
  assign snap_retire_o = s_ret_q;
  assign snap_valid_o  = valid_q;

endmodule
